comb_engine: RTL and testbench
==============================

COMB_ENGINE -- requirements
Module: comb_engine

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the width of the n and m operands.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the number of (n,m) entries the internal work stack holds.
REQ-003 The block SHALL have parameter RW, default 13, giving the width of the result.
REQ-004 Port clk SHALL be an input, 1 bit wide: the single clock; all state changes on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit wide: the reset, asynchronous and active-low.
REQ-006 Port start SHALL be an input, 1 bit wide: a request to compute C(n,m); it is sampled only in IDLE.
REQ-007 Ports n and m SHALL be inputs, each W bits wide: unsigned operands, captured on the edge that accepts start.
REQ-008 Port busy SHALL be an output, 1 bit wide: high in every state except IDLE.
REQ-009 Port done SHALL be an output, 1 bit wide: a single-cycle pulse while the FSM is in DONE.
REQ-010 Port result SHALL be an output, RW bits wide: the accumulated count, held stable from DONE until the next accepted start.
REQ-011 Ports err_arg, err_ovf and sat SHALL be outputs, each 1 bit wide: invalid-argument, stack-overflow and saturation flags, held stable from DONE until the next accepted start.

Function
REQ-012 The block SHALL compute C(n,m) by iterative DFS on an internal LIFO of {n,m} pairs: leaf when m==0 or m==n (add 1), otherwise expand to (n-1,m-1) and (n-1,m).
REQ-013 The FSM SHALL have the states IDLE, POP, EVAL, PUSH_A, PUSH_B and DONE, all registered.
REQ-014 IDLE with start=1 and m<=n: clear result and the three flags, push {n,m}, then go to POP.
REQ-015 IDLE with start=1 and m>n: set err_arg=1, set result=0, leave the stack untouched, then go to DONE.
REQ-016 POP: if the stack is empty go to DONE; otherwise pop the top entry into the working n/m registers and go to EVAL.
REQ-017 EVAL on a leaf: result += 1, then go to POP.
REQ-018 EVAL on a non-leaf: go to PUSH_A.
REQ-019 PUSH_A SHALL push {n-1,m-1} and go to PUSH_B; PUSH_B SHALL push {n-1,m} and go to POP, so the (n-1,m) branch is evaluated first.
REQ-020 A push while the stack holds DEPTH entries SHALL NOT write, SHALL set err_ovf=1, SHALL go to DONE, and SHALL leave the partial result in result.
REQ-021 An increment while result equals 2^RW-1 SHALL hold the value at 2^RW-1, set sat=1, and continue the traversal.
REQ-022 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-023 start SHALL be ignored in every state other than IDLE; start asserted in the DONE cycle SHALL NOT be accepted.
REQ-024 Latency SHALL be exactly 6*C(n,m)-3 rising edges from the edge accepting start to the edge entering DONE, for any error-free run (2 cycles per leaf, 4 per internal node, 1 final empty POP).
REQ-025 An err_arg run SHALL enter DONE on the first edge after start is accepted.
REQ-026 Any DEPTH >= 2^W SHALL guarantee that err_ovf is never set for legal operands.
REQ-027 The stack SHALL be implemented with a pointer and register array, with no read-during-write hazard: at most one push or one pop per cycle.

Reset
REQ-028 While rst=0, asynchronously: state=IDLE, stack pointer=0 (empty), result=0, busy=0, done=0, err_arg=0, err_ovf=0, sat=0.
REQ-029 Reset asserted mid-computation SHALL abort the run with no completion pulse; after release the block SHALL accept start on the first rising edge.
REQ-030 The stack array contents need not be reset.

Verification
REQ-031 W=4, n=4, m=2, start one cycle -> done at edge 33 after acceptance; result=6; all flags 0; busy high edges 1..33.
REQ-032 Leaf-only cases: n=5,m=5 -> result=1 at edge 3; n=0,m=0 -> result=1 at edge 3; n=7,m=0 -> result=1 at edge 3.
REQ-033 Invalid argument: n=2, m=3 -> done at edge 1; err_arg=1; result=0; stack remains empty.
REQ-034 DEPTH=4, n=8, m=4 -> err_ovf=1 and done pulse; then n=3, m=1 -> result=3 with err_ovf cleared.
REQ-035 RW=4, n=8, m=4 (true value 70) -> result=15, sat=1, err_ovf=0, done at edge 417.
REQ-036 Reset and start handling: rst pulsed low at edge 10 of an n=6,m=3 run -> outputs zero immediately, no done pulse; start re-issued during busy and during DONE -> ignored, current result unchanged.

Source files
------------

// File: rtl/comb_engine.sv
// comb_engine: counts C(n,m) by depth-first expansion of Pascal's rule
// over an internal LIFO of (n,m) pairs. Each leaf adds one to the result.
// The result saturates at its maximum width. A full stack aborts the run.
module comb_engine #(
  parameter int W     = 4,
  parameter int DEPTH = 16,
  parameter int RW    = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  n,
  input  logic [W-1:0]  m,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] result,
  output logic          err_arg,
  output logic          err_ovf,
  output logic          sat
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    EVAL   = 3'd2,
    PUSH_A = 3'd3,
    PUSH_B = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t         state, nxt;
  logic [PW-1:0]  sp;
  logic [PW-1:0]  sp_m1;
  logic [IW-1:0]  wr_idx;
  logic [IW-1:0]  top_idx;
  logic [W-1:0]   wn, wm;
  logic [W-1:0]   stk_n [DEPTH];
  logic [W-1:0]   stk_m [DEPTH];

  logic           push, pop, inc, go_ok, go_err, ovf_hit;
  logic [W-1:0]   pn, pm;
  logic           empty, full, leaf;

  assign sp_m1   = sp - PW'(1);
  assign wr_idx  = sp[IW-1:0];
  assign top_idx = sp_m1[IW-1:0];
  assign empty   = (sp == '0);
  assign full    = (sp == PW'(DEPTH));
  assign leaf    = (wm == '0) || (wm == wn);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // Next-state and per-cycle control decode
  always_comb begin
    nxt     = state;
    push    = 1'b0;
    pop     = 1'b0;
    inc     = 1'b0;
    go_ok   = 1'b0;
    go_err  = 1'b0;
    ovf_hit = 1'b0;
    pn      = '0;
    pm      = '0;
    case (state)
      IDLE: begin
        if (start) begin
          // An invalid request also passes through POP: the stack is
          // always empty in IDLE, so POP falls straight through to DONE,
          // giving the one-cycle-delayed completion.
          nxt = POP;
          if (m <= n) begin
            go_ok = 1'b1;
            push  = 1'b1;
            pn    = n;
            pm    = m;
          end else begin
            go_err = 1'b1;
          end
        end
      end
      POP: begin
        if (empty) begin
          nxt = DONE;
        end else begin
          pop = 1'b1;
          nxt = EVAL;
        end
      end
      EVAL: begin
        if (leaf) begin
          inc = 1'b1;
          nxt = POP;
        end else begin
          nxt = PUSH_A;
        end
      end
      PUSH_A: begin
        if (full) begin
          ovf_hit = 1'b1;
          nxt     = DONE;
        end else begin
          push = 1'b1;
          pn   = wn - W'(1);
          pm   = wm - W'(1);
          nxt  = PUSH_B;
        end
      end
      PUSH_B: begin
        if (full) begin
          ovf_hit = 1'b1;
          nxt     = DONE;
        end else begin
          push = 1'b1;
          pn   = wn - W'(1);
          pm   = wm;
          nxt  = POP;
        end
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Stack pointer, working pair, result accumulator and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp      <= '0;
      result  <= '0;
      err_arg <= 1'b0;
      err_ovf <= 1'b0;
      sat     <= 1'b0;
      wn      <= '0;
      wm      <= '0;
    end else begin
      if (go_ok || go_err) begin
        result  <= '0;
        err_arg <= go_err;
        err_ovf <= 1'b0;
        sat     <= 1'b0;
      end
      // An aborted run leaves entries behind; DONE discards them.
      if (push)               sp <= sp + PW'(1);
      else if (pop)           sp <= sp_m1;
      else if (state == DONE) sp <= '0;
      if (pop) begin
        wn <= stk_n[top_idx];
        wm <= stk_m[top_idx];
      end
      if (inc) begin
        if (result == '1) sat    <= 1'b1;
        else              result <= result + RW'(1);
      end
      if (ovf_hit) err_ovf <= 1'b1;
    end
  end

  // Stack storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push) begin
      stk_n[wr_idx] <= pn;
      stk_m[wr_idx] <= pm;
    end
  end

endmodule

// File: tb/tb_comb_engine.sv
// Bench for comb_engine: three instances (default, shallow stack, narrow
// result) share stimulus; a queue-based DFS model predicts every outcome.
module tb_comb_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  n_in = '0;
  logic [3:0]  m_in = '0;
  logic [2:0]  busy_v, done_v, arg_v, ovf_v, sat_v;
  logic [12:0] res_a, res_b;
  logic [3:0]  res_c;

  int n_cmp = 0;
  int n_bad = 0;
  int dep [3] = '{16, 4, 16};
  int rwv [3] = '{13, 13, 4};

  always #5 clk = ~clk;

  comb_engine u_a (
    .clk(clk), .rst(rst), .start(start), .n(n_in), .m(m_in),
    .busy(busy_v[0]), .done(done_v[0]), .result(res_a),
    .err_arg(arg_v[0]), .err_ovf(ovf_v[0]), .sat(sat_v[0])
  );

  comb_engine #(.DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .start(start), .n(n_in), .m(m_in),
    .busy(busy_v[1]), .done(done_v[1]), .result(res_b),
    .err_arg(arg_v[1]), .err_ovf(ovf_v[1]), .sat(sat_v[1])
  );

  comb_engine #(.RW(4)) u_c (
    .clk(clk), .rst(rst), .start(start), .n(n_in), .m(m_in),
    .busy(busy_v[2]), .done(done_v[2]), .result(res_c),
    .err_arg(arg_v[2]), .err_ovf(ovf_v[2]), .sat(sat_v[2])
  );

  function automatic int get_res(input int i);
    case (i)
      0:       return int'(res_a);
      1:       return int'(res_b);
      default: return int'(res_c);
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: explicit DFS over a queue used as a LIFO, counting edges
  // per step (pop, evaluate, each push attempt, final empty pop).
  function automatic void model(input int nn, input int mm, input int dp,
                                input int rw, output int res, output bit arg,
                                output bit ovf, output bit st, output int lat);
    int sn[$];
    int sm[$];
    int cn, cm, maxv;
    maxv = (1 << rw) - 1;
    res = 0; arg = 0; ovf = 0; st = 0; lat = 0;
    if (mm > nn) begin
      arg = 1;
      lat = 1;
      return;
    end
    sn.push_back(nn);
    sm.push_back(mm);
    while (1) begin
      lat++;
      if (sn.size() == 0) return;
      cn = sn.pop_back();
      cm = sm.pop_back();
      lat++;
      if (cm == 0 || cm == cn) begin
        if (res == maxv) st = 1;
        else res++;
      end else begin
        for (int k = 0; k < 2; k++) begin
          lat++;
          if (sn.size() == dp) begin
            ovf = 1;
            return;
          end
          sn.push_back(cn - 1);
          sm.push_back(k == 0 ? cm - 1 : cm);
        end
      end
    end
  endfunction

  // Issue one request at the current negedge and follow all three
  // instances to completion. poke re-asserts start while busy and in DONE.
  task automatic run(input int nn, input int mm, input bit poke,
                     output int res_a_o, output int lat_a_o);
    int  eres [3];
    int  elat [3];
    bit  earg [3];
    bit  eovf [3];
    bit  esat [3];
    bit  seen [3];
    int  glat [3];
    int  cyc;
    for (int i = 0; i < 3; i++) begin
      model(nn, mm, dep[i], rwv[i], eres[i], earg[i], eovf[i], esat[i], elat[i]);
      seen[i] = 0;
      glat[i] = -1;
    end
    n_in  = 4'(nn);
    m_in  = 4'(mm);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cyc < 2000) begin
      if (poke && cyc == 5) begin
        start = 1'b1; n_in = 4'd1; m_in = 4'd0;
      end else begin
        start = 1'b0;
      end
      if (cyc == 0) chk("busy_after_accept", int'(busy_v[0]), 1);
      for (int i = 0; i < 3; i++) begin
        if (!seen[i] && done_v[i]) begin
          seen[i] = 1;
          glat[i] = cyc;
          chk($sformatf("result[%0d] C(%0d,%0d)", i, nn, mm), get_res(i), eres[i]);
          chk($sformatf("err_arg[%0d]", i), int'(arg_v[i]), int'(earg[i]));
          chk($sformatf("err_ovf[%0d]", i), int'(ovf_v[i]), int'(eovf[i]));
          chk($sformatf("sat[%0d]", i), int'(sat_v[i]), int'(esat[i]));
          chk($sformatf("busy_in_done[%0d]", i), int'(busy_v[i]), 1);
        end
      end
      if (seen[0] && seen[1] && seen[2]) break;
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("latency[%0d] C(%0d,%0d)", i, nn, mm), glat[i], elat[i]);
    if (poke) begin
      start = 1'b1; n_in = 4'd1; m_in = 4'd0;
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done", int'(busy_v[0]), 0);
    chk("done_single_cycle", int'(done_v[0]), 0);
    chk("result_held", int'(res_a), eres[0]);
    res_a_o = int'(res_a);
    lat_a_o = glat[0];
  endtask

  typedef struct {
    int n;
    int m;
    int res_a;
    int lat_a;
    bit arg;
    int res_c;
    bit sat_c;
    bit ovf_b;
  } vec_t;

  initial begin
    vec_t tbl [7];
    int   r, l;
    tbl = '{
      '{4, 2,  6,  33, 1'b0,  6, 1'b0, 1'b0},
      '{5, 5,  1,   3, 1'b0,  1, 1'b0, 1'b0},
      '{0, 0,  1,   3, 1'b0,  1, 1'b0, 1'b0},
      '{7, 0,  1,   3, 1'b0,  1, 1'b0, 1'b0},
      '{2, 3,  0,   1, 1'b1,  0, 1'b0, 1'b0},
      '{8, 4, 70, 417, 1'b0, 15, 1'b1, 1'b1},
      '{3, 1,  3,  15, 1'b0,  3, 1'b0, 1'b0}
    };

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_busy[%0d]", i), int'(busy_v[i]), 0);
      chk($sformatf("reset_done[%0d]", i), int'(done_v[i]), 0);
      chk($sformatf("reset_result[%0d]", i), get_res(i), 0);
      chk($sformatf("reset_flags[%0d]", i),
          int'({arg_v[i], ovf_v[i], sat_v[i]}), 0);
    end
    rst = 1'b1;
    @(negedge clk);

    // Directed vectors
    for (int t = 0; t < 7; t++) begin
      run(tbl[t].n, tbl[t].m, 1'b0, r, l);
      chk($sformatf("tbl%0d_result", t), r, tbl[t].res_a);
      chk($sformatf("tbl%0d_latency", t), l, tbl[t].lat_a);
      chk($sformatf("tbl%0d_err_arg", t), int'(arg_v[0]), int'(tbl[t].arg));
      chk($sformatf("tbl%0d_result_c", t), int'(res_c), tbl[t].res_c);
      chk($sformatf("tbl%0d_sat_c", t), int'(sat_v[2]), int'(tbl[t].sat_c));
      chk($sformatf("tbl%0d_ovf_b", t), int'(ovf_v[1]), int'(tbl[t].ovf_b));
    end

    // start re-issued while busy and during DONE must be ignored
    run(4, 2, 1'b1, r, l);
    chk("poke_result", r, 6);
    chk("poke_latency", l, 33);

    // Asynchronous reset mid-run aborts without a completion pulse
    n_in = 4'd6; m_in = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy_v[0]), 0);
    chk("async_rst_done", int'(done_v[0]), 0);
    chk("async_rst_result", int'(res_a), 0);
    chk("async_rst_flags", int'({arg_v[0], ovf_v[0], sat_v[0]}), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_held_no_done", int'(done_v[0] | busy_v[0]), 0);
    end
    rst = 1'b1;
    run(6, 3, 1'b0, r, l);
    chk("after_rst_result", r, 20);
    chk("after_rst_latency", l, 117);

    // Randomized requests against the model
    for (int k = 0; k < 20; k++) begin
      run(int'($urandom_range(0, 9)), int'($urandom_range(0, 10)), 1'b0, r, l);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
